timestamp_counter_ctrl: RTL and testbench

Command sequencer for the 64-bit timestamp counter. It accepts host commands over a valid/ready interface and drives the counter's `start`, `offset_en` and `counter_offset` inputs: RUN, STOP, LOAD (preset) and ARM (preset then start on an external trigger edge). It sits in the counter's clock domain between the host register interface and the counter. It owns the hold time the counter's 2-flop input synchronizers need.

---
 rtl/timestamp_counter_ctrl_if.sv | 14 +
 rtl/timestamp_counter_ctrl.sv | 137 +++++++++++++
 tb/tb_timestamp_counter_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/timestamp_counter_ctrl_if.sv
// Host command channel into the timestamp counter sequencer: valid/ready
// handshake carrying an opcode and a 64-bit offset payload.
interface timestamp_counter_ctrl_if;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned DATA_W = 64;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [DATA_W-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/timestamp_counter_ctrl.sv
// Command sequencer for the 64-bit timestamp counter: RUN/STOP/LOAD/ARM with
// a trigger synchronizer and a post-LOAD hold for the counter's input syncs.
module timestamp_counter_ctrl #(
   parameter int unsigned LOAD_HOLD = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   timestamp_counter_ctrl_if.slave       cmd,
   input  logic                          trig_in,
   output logic                          start,
   output logic                          offset_en,
   output logic [63:0]                   counter_offset,
   output logic [1:0]                    state,
   output logic                          cmd_err
);

   localparam int unsigned HOLD_W = 4;
   localparam int unsigned DATA_W = 64;

   localparam logic [1:0] OP_STOP = 2'd0;
   localparam logic [1:0] OP_RUN  = 2'd1;
   localparam logic [1:0] OP_LOAD = 2'd2;
   localparam logic [1:0] OP_ARM  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_LOADING = 2'd2,
      ST_ARMED   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                start_d;
   logic                offset_en_d;
   logic [DATA_W-1:0]   offset_d;
   logic                err_d;

   logic                trig_meta, trig_sync, trig_prev;
   logic                trig_rise;
   logic                accept;
   logic                sw_fire;

   assign cmd.cmd_ready = (state_q != ST_LOADING);
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign trig_rise     = trig_sync & ~trig_prev;
   assign sw_fire       = accept & (cmd.cmd_op == OP_RUN);
   assign state         = state_q;

   // Next-state and registered-output values.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      start_d     = start;
      offset_en_d = 1'b0;
      offset_d    = counter_offset;
      err_d       = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_RUNNING: begin
            if (accept) begin
               unique case (cmd.cmd_op)
                  OP_STOP: begin
                     start_d = 1'b0;
                     state_d = ST_IDLE;
                  end
                  OP_RUN: begin
                     start_d = 1'b1;
                     state_d = ST_RUNNING;
                  end
                  OP_LOAD: begin
                     offset_d    = cmd.cmd_data;
                     offset_en_d = 1'b1;
                     hold_d      = HOLD_W'(LOAD_HOLD - 1);
                     state_d     = ST_LOADING;
                  end
                  default: begin
                     offset_d = cmd.cmd_data;
                     start_d  = 1'b0;
                     state_d  = ST_ARMED;
                  end
               endcase
            end
         end
         ST_LOADING: begin
            // Hold off the host until the counter has seen the load pulse.
            if (hold_q == '0) begin
               state_d = start ? ST_RUNNING : ST_IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_ARMED: begin
            // STOP cancels the arm even if a trigger edge arrives together.
            if (accept && (cmd.cmd_op == OP_STOP)) begin
               state_d = ST_IDLE;
            end else begin
               if (trig_rise || sw_fire) begin
                  offset_en_d = 1'b1;
                  start_d     = 1'b1;
                  state_d     = ST_RUNNING;
               end
               if (accept && ((cmd.cmd_op == OP_LOAD) || (cmd.cmd_op == OP_ARM))) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers, trigger synchronizer and edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         hold_q         <= '0;
         start          <= 1'b0;
         offset_en      <= 1'b0;
         counter_offset <= '0;
         cmd_err        <= 1'b0;
         trig_meta      <= 1'b0;
         trig_sync      <= 1'b0;
         trig_prev      <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         start          <= start_d;
         offset_en      <= offset_en_d;
         counter_offset <= offset_d;
         cmd_err        <= err_d;
         trig_meta      <= trig_in;
         trig_sync      <= trig_meta;
         trig_prev      <= trig_sync;
      end
   end

endmodule

// File: tb/tb_timestamp_counter_ctrl.sv
// Bench for timestamp_counter_ctrl: directed scenarios plus random commands,
// compared each cycle against a cycle-indexed behavioural model.
module tb_timestamp_counter_ctrl;

   localparam int unsigned HOLD   = 4;
   localparam int          NCYC   = 8192;
   localparam int          S_IDLE = 0;
   localparam int          S_RUN  = 1;
   localparam int          S_LOAD = 2;
   localparam int          S_ARM  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        trig_in;
   logic        start, offset_en, cmd_err;
   logic [63:0] counter_offset;
   logic [1:0]  state;

   timestamp_counter_ctrl_if cmd_bus ();

   timestamp_counter_ctrl #(.LOAD_HOLD(HOLD)) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd            (cmd_bus),
      .trig_in        (trig_in),
      .start          (start),
      .offset_en      (offset_en),
      .counter_offset (counter_offset),
      .state          (state),
      .cmd_err        (cmd_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: trigger samples indexed by edge number; LOADING exit by edge number.
   int          m_state = S_IDLE;
   bit          m_start, m_off_en, m_err;
   logic [63:0] m_offset = '0;
   int          m_release;
   bit          samp [NCYC];
   int          cyc = 0;
   bit          trig_lvl = 1'b0;

   task automatic model_step(input bit rst, input bit v, input bit [1:0] op,
                             input bit [63:0] d, input bit trig);
      bit rise, accept;
      rise = (cyc >= 3) && samp[cyc-2] && !samp[cyc-3];
      samp[cyc] = rst ? 1'b0 : trig;
      m_off_en = 1'b0;
      m_err    = 1'b0;
      if (rst) begin
         if (cyc >= 2) begin
            samp[cyc-1] = 1'b0;
            samp[cyc-2] = 1'b0;
         end
         m_state  = S_IDLE;
         m_start  = 1'b0;
         m_offset = '0;
      end else begin
         accept = v && (m_state != S_LOAD);
         case (m_state)
            S_IDLE, S_RUN: if (accept) begin
               case (op)
                  2'd0: begin m_start = 1'b0; m_state = S_IDLE; end
                  2'd1: begin m_start = 1'b1; m_state = S_RUN; end
                  2'd2: begin
                     m_offset = d; m_off_en = 1'b1;
                     m_release = cyc + int'(HOLD); m_state = S_LOAD;
                  end
                  default: begin m_offset = d; m_start = 1'b0; m_state = S_ARM; end
               endcase
            end
            S_LOAD: if (cyc == m_release) m_state = m_start ? S_RUN : S_IDLE;
            default: begin
               if (accept && op == 2'd0) m_state = S_IDLE;
               else begin
                  if (rise || (accept && op == 2'd1)) begin
                     m_off_en = 1'b1; m_start = 1'b1; m_state = S_RUN;
                  end
                  if (accept && op[1]) m_err = 1'b1;
               end
            end
         endcase
      end
      cyc++;
   endtask

   // Drive one cycle of inputs, advance model and DUT, compare everything.
   task automatic cycle(input bit rst, input bit v, input bit [1:0] op,
                        input bit [63:0] d, input bit trig);
      reset             = rst;
      cmd_bus.cmd_valid = v;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_data  = d;
      trig_in           = trig;
      model_step(rst, v, op, d, trig);
      @(posedge clk);
      @(negedge clk);
      check("state",          64'(state),             64'(m_state));
      check("start",          64'(start),             64'(m_start));
      check("offset_en",      64'(offset_en),         64'(m_off_en));
      check("counter_offset", counter_offset,         m_offset);
      check("cmd_err",        64'(cmd_err),           64'(m_err));
      check("cmd_ready",      64'(cmd_bus.cmd_ready), 64'(m_state != S_LOAD));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 64'd0, trig_lvl);
   endtask

   task automatic send(input bit [1:0] op, input bit [63:0] d);
      cycle(1'b0, 1'b1, op, d, trig_lvl);
   endtask

   initial begin
      int lows, lat;

      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'd0, 64'd0, 1'b0);
      check("reset_state", 64'(state), 64'(S_IDLE));

      idle(6);
      send(2'd1, 64'd0);
      check("run_start", 64'(start), 64'd1);

      send(2'd2, 64'h1000);
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         if (cmd_bus.cmd_ready) break;
         lows++;
         idle(1);
      end
      check("load_hold_cycles", 64'(lows), 64'(HOLD));
      check("load_back_running", 64'(state), 64'(S_RUN));

      send(2'd3, 64'hFFFF_FFFF_FFFF_FFFE);
      idle(20);
      trig_lvl = 1'b1;
      idle(1);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         if (offset_en) break;
         idle(1);
         lat++;
      end
      check("trig_latency", 64'(lat), 64'd2);
      check("trig_offset", counter_offset, 64'hFFFF_FFFF_FFFF_FFFE);
      trig_lvl = 1'b0;
      idle(3);

      trig_lvl = 1'b1;
      idle(4);
      send(2'd3, 64'h55);
      idle(10);
      check("held_trig_no_fire", 64'(state), 64'(S_ARM));
      trig_lvl = 1'b0;
      idle(2);
      trig_lvl = 1'b1;
      idle(4);
      check("new_edge_fires", 64'(state), 64'(S_RUN));
      trig_lvl = 1'b0;

      send(2'd0, 64'd0);
      send(2'd3, 64'h77);
      send(2'd2, 64'h99);
      check("armed_load_err", 64'(cmd_err), 64'd1);
      check("armed_load_kept", counter_offset, 64'h77);
      send(2'd1, 64'd0);
      check("sw_fire", 64'(state), 64'(S_RUN));

      send(2'd3, 64'h1234);
      idle(3);
      trig_lvl = 1'b1;
      idle(2);
      send(2'd0, 64'd0);
      check("stop_beats_trig", 64'(state), 64'(S_IDLE));
      trig_lvl = 1'b0;
      send(2'd3, 64'h4321);
      idle(3);
      trig_lvl = 1'b1;
      idle(2);
      send(2'd1, 64'd0);
      check("run_and_trig_fire", 64'(offset_en), 64'd1);
      idle(1);
      check("run_and_trig_once", 64'(offset_en), 64'd0);
      trig_lvl = 1'b0;

      send(2'd2, 64'hABCD);
      cycle(1'b1, 1'b0, 2'd0, 64'd0, trig_lvl);
      check("reset_in_loading", 64'(state), 64'(S_IDLE));
      send(2'd3, 64'hBEEF);
      idle(2);
      cycle(1'b1, 1'b0, 2'd0, 64'd0, trig_lvl);
      check("reset_in_armed", counter_offset, 64'd0);
      trig_lvl = 1'b1;
      idle(5);
      check("trig_after_reset", 64'(start), 64'd0);
      trig_lvl = 1'b0;
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         bit rst, v;
         if ($urandom_range(7) == 0) trig_lvl = ~trig_lvl;
         rst = ($urandom_range(199) == 0);
         v   = ($urandom_range(2) == 0);
         cycle(rst, v, 2'($urandom_range(3)), {$urandom(), $urandom()}, trig_lvl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
